alp_operand_stage: RTL

ALP_OPERAND_STAGE -- requirements
Module: alp_operand_stage

---
 rtl/alp_operand_stage.sv | 170 +++++++++++++++++
 1 files changed

// File: rtl/alp_operand_stage.sv
// ---------------------------------------------------------------------------
// alp_operand_stage
//
// Purpose:
//   Operand selection and staging for the ALP datapath. Two wired-OR style
//   source buses (A and B) are formed from one-hot select vectors. The chosen
//   operands are captured into a one-entry valid/ready pipeline register.
//   The stage also holds the D and Q scratch registers, which feed back into
//   the A and B muxes, and a sticky flag for select-encoding errors.
//
// Ports:
//   clk            in   rising-edge clock
//   reset_l        in   asynchronous active-low reset
//   amux_onehot_h  in   A select {RBUS, MBUS, DREG, PAD}, bit 3..0
//   bmux_onehot_h  in   B select {RBUS, QREG, SHIFTER}, bit 2..0
//   rbus_h         in   R bus source
//   mbus_h         in   M bus source
//   pad_h          in   pad source
//   shf_h          in   shifter source
//   dreg_ld_h      in   D register load strobe
//   dreg_in_h      in   D register load data
//   qreg_ld_h      in   Q register load strobe
//   qreg_in_h      in   Q register load data
//   in_valid_h     in   upstream operand valid
//   in_ready_h     out  stage can accept an operand this cycle
//   out_valid_h    out  staged operands valid
//   out_ready_h    in   downstream takes staged operands
//   a_op_h         out  staged A operand
//   b_op_h         out  staged B operand
//   dreg_h         out  D register contents
//   qreg_h         out  Q register contents
//   sel_err_h      out  sticky select-encoding error
//   err_clr_h      in   synchronous clear for sel_err_h
// ---------------------------------------------------------------------------
module alp_operand_stage #(
   parameter int unsigned WIDTH = 8
) (
   input  logic             clk,
   input  logic             reset_l,
   input  logic [3:0]       amux_onehot_h,
   input  logic [2:0]       bmux_onehot_h,
   input  logic [WIDTH-1:0] rbus_h,
   input  logic [WIDTH-1:0] mbus_h,
   input  logic [WIDTH-1:0] pad_h,
   input  logic [WIDTH-1:0] shf_h,
   input  logic             dreg_ld_h,
   input  logic             qreg_ld_h,
   input  logic [WIDTH-1:0] dreg_in_h,
   input  logic [WIDTH-1:0] qreg_in_h,
   input  logic             in_valid_h,
   output logic             in_ready_h,
   output logic             out_valid_h,
   input  logic             out_ready_h,
   output logic [WIDTH-1:0] a_op_h,
   output logic [WIDTH-1:0] b_op_h,
   output logic [WIDTH-1:0] dreg_h,
   output logic [WIDTH-1:0] qreg_h,
   output logic             sel_err_h,
   input  logic             err_clr_h
);

   // State
   logic             out_valid_q, out_valid_d;
   logic [WIDTH-1:0] a_op_q, a_op_d;
   logic [WIDTH-1:0] b_op_q, b_op_d;
   logic [WIDTH-1:0] dreg_q, dreg_d;
   logic [WIDTH-1:0] qreg_q, qreg_d;
   logic             sel_err_q, sel_err_d;

   // Combinational intermediates
   logic [WIDTH-1:0] a_mux;
   logic [WIDTH-1:0] b_mux;
   logic             amux_ok;
   logic             bmux_ok;
   logic             accept;

   // A/B operand buses. Each source is gated by its select bit and the
   // results are ORed, so zero-hot gives zero and multi-hot merges sources
   // exactly as the original wired-OR bus did. D and Q are the registered
   // (pre-edge) values, so a same-cycle load is not visible here.
   always_comb begin
      a_mux = ({WIDTH{amux_onehot_h[3]}} & rbus_h)
            | ({WIDTH{amux_onehot_h[2]}} & mbus_h)
            | ({WIDTH{amux_onehot_h[1]}} & dreg_q)
            | ({WIDTH{amux_onehot_h[0]}} & pad_h);
      b_mux = ({WIDTH{bmux_onehot_h[2]}} & rbus_h)
            | ({WIDTH{bmux_onehot_h[1]}} & qreg_q)
            | ({WIDTH{bmux_onehot_h[0]}} & shf_h);
   end

   // Exactly-one-bit-set test: nonzero and clearing the lowest set bit
   // leaves nothing.
   always_comb begin
      amux_ok = (amux_onehot_h != 4'd0)
             && ((amux_onehot_h & (amux_onehot_h - 4'd1)) == 4'd0);
      bmux_ok = (bmux_onehot_h != 3'd0)
             && ((bmux_onehot_h & (bmux_onehot_h - 3'd1)) == 3'd0);
   end

   // Handshake: the single entry is free when empty or being drained now.
   always_comb begin
      in_ready_h = ~out_valid_q | out_ready_h;
      accept     = in_valid_h & in_ready_h;
   end

   // Next-state logic
   always_comb begin
      out_valid_d = out_valid_q;
      a_op_d      = a_op_q;
      b_op_d      = b_op_q;
      dreg_d      = dreg_q;
      qreg_d      = qreg_q;
      sel_err_d   = sel_err_q;

      // Accept covers the back-to-back case: new operands replace the
      // drained ones and valid stays high.
      if (accept) begin
         out_valid_d = 1'b1;
         a_op_d      = a_mux;
         b_op_d      = b_mux;
      end else if (out_valid_q && out_ready_h) begin
         out_valid_d = 1'b0;
      end

      // D/Q loads are independent of the operand handshake.
      if (dreg_ld_h) begin
         dreg_d = dreg_in_h;
      end
      if (qreg_ld_h) begin
         qreg_d = qreg_in_h;
      end

      // Set has priority over clear so an error is never lost.
      if (accept && !(amux_ok && bmux_ok)) begin
         sel_err_d = 1'b1;
      end else if (err_clr_h) begin
         sel_err_d = 1'b0;
      end
   end

   // State register
   always_ff @(posedge clk or negedge reset_l) begin
      if (!reset_l) begin
         out_valid_q <= 1'b0;
         a_op_q      <= '0;
         b_op_q      <= '0;
         dreg_q      <= '0;
         qreg_q      <= '0;
         sel_err_q   <= 1'b0;
      end else begin
         out_valid_q <= out_valid_d;
         a_op_q      <= a_op_d;
         b_op_q      <= b_op_d;
         dreg_q      <= dreg_d;
         qreg_q      <= qreg_d;
         sel_err_q   <= sel_err_d;
      end
   end

   // Outputs
   always_comb begin
      out_valid_h = out_valid_q;
      a_op_h      = a_op_q;
      b_op_h      = b_op_q;
      dreg_h      = dreg_q;
      qreg_h      = qreg_q;
      sel_err_h   = sel_err_q;
   end

endmodule
